// File: rtl/uart_pkg.sv
// uart_pkg: types and helpers shared by the UART receive and transmit paths
package uart_pkg;
    localparam int UART_DATA_BITS = 8;
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_rx_state_t;
    function automatic int clks_per_bit(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchroniser for asynchronous inputs with a configurable reset value
module sync_2ff #(
    parameter int WIDTH = 1,
    parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b1}}
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);
    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_meta <= RST_VAL;
            r_sync <= RST_VAL;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end
    assign o_q = r_sync;
endmodule

// File: rtl/uart_rx_deser.sv
// uart_rx_deser: 8N1 UART receiver with a one-entry valid/ready holding register and error pulses
module uart_rx_deser
    import uart_pkg::*;
#(
    parameter int CLK_HZ = 25_000_000,
    parameter int BAUD   = 115_200
) (
    input  logic                      pll_clk,
    input  logic                      rst_n,
    input  logic                      rx_pin,
    output logic [UART_DATA_BITS-1:0] out_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      framing_err,
    output logic                      overrun_err,
    output logic                      busy
);
    localparam int CLKS_PER_BIT = clks_per_bit(CLK_HZ, BAUD);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int IW = $clog2(UART_DATA_BITS);
    localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(UART_DATA_BITS - 1);

    uart_rx_state_t            r_state, w_state_nxt;
    logic [CW-1:0]             r_cnt, w_cnt_nxt;
    logic [IW-1:0]             r_idx, w_idx_nxt;
    logic [UART_DATA_BITS-1:0] r_shreg, w_shreg_nxt;
    logic [UART_DATA_BITS-1:0] r_data;
    logic                      r_valid, r_ferr, r_oerr;
    logic                      w_rxs, w_tick, w_done, w_ferr;

    sync_2ff #(.WIDTH(1), .RST_VAL(1'b1)) u_sync (
        .i_clk   (pll_clk),
        .i_rst_n (rst_n),
        .i_d     (rx_pin),
        .o_q     (w_rxs)
    );

    assign w_tick = (r_cnt == '0);

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = w_tick ? '0 : r_cnt - CW'(1);
        w_idx_nxt   = r_idx;
        w_shreg_nxt = r_shreg;
        w_done      = 1'b0;
        w_ferr      = 1'b0;
        case (r_state)
            IDLE: begin
                if (!w_rxs) begin
                    w_state_nxt = START;
                    w_cnt_nxt   = CNT_HALF;
                end
            end
            START: begin
                if (w_tick) begin
                    w_state_nxt = w_rxs ? IDLE : DATA;
                    w_cnt_nxt   = w_rxs ? '0 : CNT_FULL;
                    w_idx_nxt   = '0;
                end
            end
            DATA: begin
                if (w_tick) begin
                    w_shreg_nxt[r_idx] = w_rxs;
                    w_cnt_nxt          = CNT_FULL;
                    w_idx_nxt          = r_idx + IW'(1);
                    w_state_nxt        = (r_idx == IDX_LAST) ? STOP : DATA;
                end
            end
            STOP: begin
                // leave half a bit early so the next start edge is never missed
                if (w_tick) begin
                    w_state_nxt = IDLE;
                    w_done      = w_rxs;
                    w_ferr      = !w_rxs;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge pll_clk) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    always_ff @(posedge pll_clk) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            r_idx   <= '0;
            r_shreg <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
            r_ferr  <= 1'b0;
            r_oerr  <= 1'b0;
        end else begin
            r_cnt   <= w_cnt_nxt;
            r_idx   <= w_idx_nxt;
            r_shreg <= w_shreg_nxt;
            r_ferr  <= w_ferr;
            r_oerr  <= w_done && r_valid && !out_ready;
            if (w_done && (!r_valid || out_ready)) begin
                r_data  <= r_shreg;
                r_valid <= 1'b1;
            end else if (r_valid && out_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign out_data    = r_data;
    assign out_valid   = r_valid;
    assign framing_err = r_ferr;
    assign overrun_err = r_oerr;
    assign busy        = (r_state != IDLE);
endmodule

// File: tb/tb_uart_rx_deser.sv
// tb_uart_rx_deser: directed frames at 8 clocks per bit with hand-computed expectations
`timescale 1ns/1ps
module tb_uart_rx_deser;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx = 1'b1;
    logic       ready = 1'b1;
    logic [7:0] out_data;
    logic       out_valid, framing_err, overrun_err, busy;

    int         n_chk = 0, n_pass = 0;
    int         n_acc = 0, n_fe = 0, n_ov = 0, n_busy = 0;
    logic [7:0] last = 8'h00;
    int         a0, f0, o0, b0;

    uart_rx_deser #(.CLK_HZ(800), .BAUD(100)) dut (
        .pll_clk     (clk),
        .rst_n       (rst_n),
        .rx_pin      (rx),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (ready),
        .framing_err (framing_err),
        .overrun_err (overrun_err),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (out_valid && ready) begin
            n_acc <= n_acc + 1;
            last  <= out_data;
        end
        if (framing_err) n_fe <= n_fe + 1;
        if (overrun_err) n_ov <= n_ov + 1;
        if (busy) n_busy <= n_busy + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic snap();
        a0 = n_acc;
        f0 = n_fe;
        o0 = n_ov;
        b0 = n_busy;
    endtask

    // frame edges land just before a rising edge to keep sample points well inside each bit
    task automatic send(input logic [7:0] b, input logic stop, input realtime bp);
        @(negedge clk);
        #4;
        rx = 1'b0;
        #(bp);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            #(bp);
        end
        rx = stop;
        #(bp);
        rx = 1'b1;
    endtask

    initial begin
        logic [7:0] pb;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_data", out_data, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_ferr", framing_err, 0);
        chk("rst_oerr", overrun_err, 0);
        chk("rst_busy", busy, 0);
        @(posedge clk) #1 rst_n = 1'b1;
        idle(5);

        snap();
        send(8'hA5, 1'b1, 80.0);
        idle(20);
        chk("t1_count", n_acc - a0, 1);
        chk("t1_data", last, 8'hA5);
        chk("t1_ferr", n_fe - f0, 0);
        chk("t1_oerr", n_ov - o0, 0);
        chk("t1_busy", busy, 0);

        ready = 1'b0;
        snap();
        send(8'h00, 1'b1, 80.0);
        send(8'hFF, 1'b1, 80.0);
        idle(20);
        @(negedge clk);
        chk("t2_valid", out_valid, 1);
        chk("t2_data", out_data, 8'h00);
        chk("t2_oerr", n_ov - o0, 1);
        chk("t2_ferr", n_fe - f0, 0);
        chk("t2_noacc", n_acc - a0, 0);
        @(posedge clk) #1 ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("t2_drain", out_valid, 0);
        chk("t2_acc", n_acc - a0, 1);
        chk("t2_accdata", last, 8'h00);

        snap();
        @(posedge clk) #1 rx = 1'b0;
        repeat (3) @(posedge clk);
        #1 rx = 1'b1;
        idle(20);
        chk("t3_busyseen", n_busy - b0 > 0, 1);
        chk("t3_busy", busy, 0);
        chk("t3_acc", n_acc - a0, 0);
        chk("t3_ferr", n_fe - f0, 0);

        snap();
        send(8'h3C, 1'b0, 80.0);
        idle(20);
        chk("t4_ferr", n_fe - f0, 1);
        chk("t4_noacc", n_acc - a0, 0);
        chk("t4_oerr", n_ov - o0, 0);
        send(8'h81, 1'b1, 80.0);
        idle(20);
        chk("t4_acc", n_acc - a0, 1);
        chk("t4_data", last, 8'h81);
        chk("t4_ferr2", n_fe - f0, 1);

        ready = 1'b0;
        send(8'h11, 1'b1, 80.0);
        idle(5);
        snap();
        pb = 8'h5A;
        @(negedge clk);
        #4 rx = 1'b0;
        #80;
        for (int i = 0; i < 4; i++) begin
            rx = pb[i];
            #80;
        end
        rx = pb[4];
        #40;
        @(posedge clk) #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("t5_data", out_data, 0);
        chk("t5_valid", out_valid, 0);
        chk("t5_ferr", framing_err, 0);
        chk("t5_oerr", overrun_err, 0);
        chk("t5_busy", busy, 0);
        @(posedge clk) #1;
        rst_n = 1'b1;
        rx = 1'b1;
        ready = 1'b1;
        idle(20);
        send(8'hC3, 1'b1, 80.0);
        idle(20);
        chk("t5_acc", n_acc - a0, 1);
        chk("t5_data2", last, 8'hC3);
        chk("t5_nferr", n_fe - f0, 0);

        snap();
        send(8'h96, 1'b1, 76.8);
        idle(20);
        chk("t6_fast_acc", n_acc - a0, 1);
        chk("t6_fast_data", last, 8'h96);
        send(8'h96, 1'b1, 83.2);
        idle(20);
        chk("t6_slow_acc", n_acc - a0, 2);
        chk("t6_slow_data", last, 8'h96);
        chk("t6_ferr", n_fe - f0, 0);
        chk("t6_oerr", n_ov - o0, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
